booth_seq_ctrl: RTL
===================

// Module: booth_seq_ctrl
//
// PURPOSE
//  Sequential radix-2 Booth multiplier controller. Accepts one signed operand
//  pair over a valid/ready handshake. Runs Width add/shift iterations through
//  an internal Booth-table mux4x1 (sel={Q[0],Q_1}: 01 -> +M, 10 -> -M,
//  00/11 -> 0). Returns the signed 2*Width-bit product over a second
//  valid/ready handshake. Sits between the operand source and the product
//  consumer; one multiplication is in flight at a time.
//
// PARAMETERS
//  Width  16                 operand width in bits (>=2)
//  CntW   $clog2(Width+1)    iteration counter width (derived, do not override)
//
// PORTS
//  clk            in   1        single clock, rising edge
//  rst_n          in   1        asynchronous, active-low reset
//  in_valid       in   1        operand pair valid
//  in_ready       out  1        controller can accept operands (IDLE only)
//  multiplicand   in   Width    signed M, sampled on in handshake
//  multiplier     in   Width    signed Q, sampled on in handshake
//  out_valid      out  1        product valid (DONE only)
//  out_ready      in   1        consumer accepts product
//  product        out  2*Width  signed M*Q
//  busy           out  1        high in CALC or DONE
//
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; A, Q, Q_1, M, cnt,
//    product all 0. in_ready=1 after reset. out_valid=0. busy=0.
//  - Registers:
//    - A: Width+1 bits. Extra bit absorbs negation of -2^(Width-1).
//    - M: Width+1 bits, sign-extended multiplicand.
//    - Q: Width bits. Q_1: 1 bit. cnt: CntW bits.
//  - Mux instance width Width+1; seg0=M, seg1=(~M)+1 (two's complement, Width+1 bits).
//  - FSM states IDLE, CALC, DONE:
//    - IDLE: in_ready=1. On in_valid&&in_ready: load M, Q=multiplier,
//      A=0, Q_1=0, cnt=Width. Go to CALC. Otherwise hold.
//    - CALC: in_ready=0, in_valid ignored. Each cycle:
//      - sum = A + mux_out, wrapping mod 2^(Width+1).
//      - {A,Q,Q_1} <= arithmetic shift right by 1 of {sum,Q,Q_1}; sign = sum[Width].
//      - cnt <= cnt-1.
//      - On the cycle cnt==1, also register product <= {A_next[Width-1:0], Q_next}.
//        Go to DONE.
//    - DONE: out_valid=1. product held stable while out_valid && !out_ready.
//      On out_ready: go to IDLE. No new accept in the same cycle.
//  - Latency: exactly Width cycles from the accept edge to the edge that raises
//    out_valid. Minimum initiation interval is Width+2 cycles.
//  - product keeps its last value in IDLE. Inputs are don't-care outside
//    the accept cycle.
//  - Boundaries:
//    - Most-negative x most-negative is exact: 2^(2*Width-2) fits in 2*Width signed bits.
//    - multiplier=0 still takes Width cycles; no early termination.
//  - Reset mid-CALC/DONE: immediate return to IDLE with reset values.
//    Partial result discarded; no out_valid pulse.
//  - X-free outputs; no combinational path from in_valid to in_ready or from
//    out_ready to out_valid.
//
// TESTING (Width=16)
//  1. M=3, Q=5 -> after 16 cycles out_valid=1, product=32'h0000_000F;
//     in_ready low throughout CALC/DONE.
//  2. M=-7, Q=3 -> product=32'hFFFF_FFEB.
//     M=7, Q=-3 -> product=32'hFFFF_FFEB.
//  3. M=16'h8000, Q=16'h8000 -> product=32'h4000_0000.
//     M=16'h8000, Q=1 -> product=32'hFFFF_8000.
//  4. out_ready held low 5 cycles in DONE -> out_valid and product stable
//     throughout. out_ready=1 -> IDLE next cycle, in_ready=1.
//  5. in_valid pulsed with new operands during CALC -> ignored.
//     Result of the first pair is unchanged.
//  6. rst_n low at iteration 8 -> all outputs reset asynchronously.
//     After release, M=2, Q=-2 gives 32'hFFFF_FFFC.
//  Plus: random signed operands vs reference multiply, back-to-back with random out_ready.

Source files
------------

// File: rtl/booth_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : booth_seq_ctrl
//  Description : Sequential radix-2 Booth multiplier controller. Accepts one
//                signed operand pair over a valid/ready handshake, runs WIDTH
//                add/shift iterations and returns the signed 2*WIDTH-bit
//                product over a second valid/ready handshake. One
//                multiplication is in flight at a time.
//
//  Ports       : clk          - clock, rising edge
//                rst_n        - asynchronous active-low reset
//                in_valid     - operand pair valid
//                in_ready     - operands can be accepted (IDLE only)
//                multiplicand - signed M, sampled on input handshake
//                multiplier   - signed Q, sampled on input handshake
//                out_valid    - product valid (DONE only)
//                out_ready    - consumer accepts product
//                product      - signed M*Q
//                busy         - high while calculating or holding a result
//
//  Revision    : 1.0  initial release
// ============================================================================
module booth_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [WIDTH:0]   c_one      = {{WIDTH{1'b0}}, 1'b1};

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;

    // A and M carry one extra bit so that negating -2^(WIDTH-1) cannot overflow.
    logic [WIDTH:0]       r_a;
    logic [WIDTH:0]       r_m;
    logic [WIDTH-1:0]     r_q;
    logic                 r_q1;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_product;

    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH:0]       w_m_neg;
    logic [WIDTH:0]       w_mux;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_a_nxt;
    logic [WIDTH-1:0]     w_q_nxt;
    logic                 w_q1_nxt;

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_last   = (r_state == S_CALC) && (r_cnt == c_cnt_one);

    // Booth recoding table: {Q[0],Q_1} = 01 adds M, 10 subtracts M, else 0.
    assign w_m_neg = (~r_m) + c_one;

    always_comb begin
        w_mux = '0;
        case ({r_q[0], r_q1})
            2'b01:   w_mux = r_m;
            2'b10:   w_mux = w_m_neg;
            default: w_mux = '0;
        endcase
    end

    // Add wraps mod 2^(WIDTH+1); the arithmetic shift of {sum,Q,Q_1} replicates sum's MSB.
    assign w_sum    = r_a + w_mux;
    assign w_a_nxt  = {w_sum[WIDTH], w_sum[WIDTH:1]};
    assign w_q_nxt  = {w_sum[0], r_q[WIDTH-1:1]};
    assign w_q1_nxt = r_q[0];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_nxt = S_CALC;
            S_CALC:  if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (pure functions of state, so no input-to-output paths)
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_IDLE:  in_ready = 1'b1;
            S_CALC:  busy     = 1'b1;
            S_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    assign product = r_product;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_q1      <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_a   <= '0;
            r_m   <= {multiplicand[WIDTH-1], multiplicand};
            r_q   <= multiplier;
            r_q1  <= 1'b0;
            r_cnt <= c_cnt_load;
        end else if (r_state == S_CALC) begin
            r_a   <= w_a_nxt;
            r_q   <= w_q_nxt;
            r_q1  <= w_q1_nxt;
            r_cnt <= r_cnt - c_cnt_one;
            // The low 2*WIDTH bits of {A,Q} already hold the exact product.
            if (w_last) begin
                r_product <= {w_a_nxt[WIDTH-1:0], w_q_nxt};
            end
        end
    end

endmodule
`default_nettype wire
